// File: rtl/sensor_pkg.sv
// sensor_pkg: shared types, widths and the per-bank error equation
package sensor_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, EVAL} scan_state_t;

    localparam int SENSOR_W = 4;

    // A bank is erroneous when bit 0 is set, or bit 1 together with either upper bit
    function automatic logic sensor_err(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: per-bank consecutive-error counter with a sticky fault flag
module sensor_debounce import sensor_pkg::*; #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic upd,
    input  logic err,
    input  logic clr,
    output logic fault
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          fault_q, fault_d, set;

    // Saturating count of consecutive errors; a set on the same edge overrides a clear
    always_comb begin
        cnt_inc = (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + CW'(1);
        set     = upd & err & (cnt_inc == CW'(DEBOUNCE));
        cnt_d   = set ? CW'(DEBOUNCE) : clr ? '0 : upd ? (err ? cnt_inc : '0) : cnt_q;
        fault_d = set | (fault_q & ~clr);
    end

    // Counter and fault state registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

endmodule

// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: round-robin sensor bank scanner with debounced sticky faults and clear handshake
module sensor_scan_ctrl import sensor_pkg::*; #(
    parameter int NUM_BANKS = 4,
    parameter int DEBOUNCE  = 3
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          enable,
    input  logic [SENSOR_W*NUM_BANKS-1:0] sensor_bus,
    input  logic                          clear_req,
    input  logic [NUM_BANKS-1:0]          clear_mask,
    output logic                          clear_ack,
    output logic [NUM_BANKS-1:0]          fault,
    output logic                          fault_irq,
    output logic                          scan_done,
    output logic                          busy,
    output logic [$clog2(NUM_BANKS)-1:0]  cur_bank
);

    localparam int             BW   = $clog2(NUM_BANKS);
    localparam logic [BW-1:0]  LAST = BW'(NUM_BANKS - 1);

    scan_state_t         state_q, state_d;
    logic [BW-1:0]       cur_bank_q, cur_bank_d;
    logic [SENSOR_W-1:0] sample_q, sample_d, bank_nib;
    logic                busy_q, busy_d, scan_done_q, scan_done_d;
    logic                clear_ack_q, clear_ack_d, fault_irq_q, fault_irq_d;
    logic                last, do_clr, err;
    logic [NUM_BANKS-1:0] fault_w;

    // Select the nibble of the bank currently being scanned
    always_comb begin
        bank_nib = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (cur_bank_q == BW'(b)) bank_nib = sensor_bus[b*SENSOR_W +: SENSOR_W];
    end

    // Next-state logic; cur_bank survives IDLE so a paused scan resumes where it stopped
    always_comb begin
        last        = cur_bank_q == LAST;
        do_clr      = clear_req & ~clear_ack_q;
        err         = sensor_err(sample_q);
        state_d     = state_q;
        cur_bank_d  = cur_bank_q;
        sample_d    = sample_q;
        case (state_q)
            IDLE:    state_d = enable ? SAMPLE : IDLE;
            SAMPLE: begin
                sample_d = bank_nib;
                state_d  = EVAL;
            end
            EVAL: begin
                cur_bank_d = last ? '0 : cur_bank_q + BW'(1);
                state_d    = enable ? SAMPLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d      = state_d != IDLE;
        scan_done_d = (state_q == EVAL) & last;
        clear_ack_d = do_clr;
        fault_irq_d = |fault_w;
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cur_bank_q  <= '0;
            sample_q    <= '0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            clear_ack_q <= 1'b0;
            fault_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_bank_q  <= cur_bank_d;
            sample_q    <= sample_d;
            busy_q      <= busy_d;
            scan_done_q <= scan_done_d;
            clear_ack_q <= clear_ack_d;
            fault_irq_q <= fault_irq_d;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_deb
        sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk   (clk),
            .n_rst (n_rst),
            .upd   ((state_q == EVAL) && (cur_bank_q == BW'(g))),
            .err   (err),
            .clr   (do_clr & clear_mask[g]),
            .fault (fault_w[g])
        );
    end

    assign fault     = fault_w;
    assign fault_irq = fault_irq_q;
    assign scan_done = scan_done_q;
    assign busy      = busy_q;
    assign cur_bank  = cur_bank_q;
    assign clear_ack = clear_ack_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl: randomized and directed checks against a scan-position reference model
module tb_sensor_scan_ctrl;

    localparam int N = 4;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic           enable = 1'b0;
    logic [4*N-1:0] sensor_bus = '0;
    logic           clear_req = 1'b0;
    logic [N-1:0]   clear_mask = '0;
    logic           clear_ack, fault_irq, scan_done, busy;
    logic [N-1:0]   fault;
    logic [1:0]     cur_bank;

    sensor_scan_ctrl #(.NUM_BANKS(N), .DEBOUNCE(D)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (enable),
        .sensor_bus (sensor_bus),
        .clear_req  (clear_req),
        .clear_mask (clear_mask),
        .clear_ack  (clear_ack),
        .fault      (fault),
        .fault_irq  (fault_irq),
        .scan_done  (scan_done),
        .busy       (busy),
        .cur_bank   (cur_bank)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: m_pos counts half-bank steps 0..2N-1 (even = capture, odd = judge)
    bit           m_act;
    int           m_pos, m_samp, m_irq, m_done, m_ack;
    int           m_cnt[N];
    logic [N-1:0] m_flt;

    function automatic bit err_of(input int s);
        return (s % 2 == 1) || (((s / 2) % 2 == 1) && s >= 4);
    endfunction

    task automatic model_reset();
        m_act = 0; m_pos = 0; m_samp = 0; m_irq = 0; m_done = 0; m_ack = 0; m_flt = '0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] old_flt;
        bit judge, e, na;
        int b, c;
        old_flt = m_flt;
        na      = clear_req && (m_ack == 0);
        judge   = m_act && (m_pos % 2 == 1);
        b       = m_pos / 2;
        e       = err_of(m_samp);
        for (int k = 0; k < N; k++) begin
            if (judge && k == b) begin
                c = e ? ((m_cnt[k] + 1 > D) ? D : m_cnt[k] + 1) : 0;
                if (e && c == D) begin
                    m_flt[k] = 1'b1;
                    m_cnt[k] = D;
                end else if (na && clear_mask[k]) begin
                    m_flt[k] = 1'b0;
                    m_cnt[k] = 0;
                end else m_cnt[k] = c;
            end else if (na && clear_mask[k]) begin
                m_flt[k] = 1'b0;
                m_cnt[k] = 0;
            end
        end
        m_irq  = (old_flt != 0);
        m_done = m_act && (m_pos == 2*N - 1);
        m_ack  = na;
        if (!m_act) begin
            if (enable) m_act = 1;
        end else if (m_pos % 2 == 0) begin
            m_samp = int'((sensor_bus >> (4 * (m_pos / 2))) & 16'hF);
            m_pos++;
        end else begin
            m_pos = (m_pos + 1) % (2*N);
            m_act = enable;
        end
    endtask

    task automatic compare();
        check("busy", busy, m_act);
        check("cur_bank", cur_bank, m_pos / 2);
        check("fault", fault, m_flt);
        check("fault_irq", fault_irq, m_irq);
        check("scan_done", scan_done, m_done);
        check("clear_ack", clear_ack, m_ack);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_clear(input logic [N-1:0] mask);
        clear_req  = 1'b1;
        clear_mask = mask;
        cycle();
        clear_req  = 1'b0;
    endtask

    task automatic async_reset();
        #3 n_rst = 1'b0;
        #1 model_reset();
        compare();
        @(posedge clk);
        #1;
        compare();
        n_rst = 1'b1;
    endtask

    logic [4*N-1:0] rnd_bus;
    bit             raced, hit;

    initial begin
        model_reset();
        enable = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            sensor_bus = 16'($urandom);
            compare();
        end
        n_rst = 1'b1;

        sensor_bus = 16'h0000;
        run(40);
        sensor_bus = 16'h2222;
        run(24);
        sensor_bus = 16'h4444;
        run(24);

        sensor_bus = 16'h0600;
        run(2*N*D + 4);
        sensor_bus = 16'h0000;
        run(6);
        pulse_clear(4'b0100);
        run(4);

        for (int s = 0; s < 6; s++) begin
            sensor_bus = (s % 2 == 0) ? 16'h0010 : 16'h0000;
            run(2*N);
        end

        pulse_clear(4'b1111);
        sensor_bus = 16'h0600;
        raced = 0;
        for (int i = 0; i < 200 && !raced; i++) begin
            if (m_act && m_pos == 5 && m_cnt[2] == D - 1 && err_of(m_samp)) begin
                raced = 1;
                pulse_clear(4'b0100);
            end else cycle();
        end
        check("race_hit", raced, 1);
        run(3);
        sensor_bus = 16'h0000;
        run(10);
        pulse_clear(4'b0100);
        run(4);

        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (m_act && m_pos == 2) begin
                hit = 1;
                enable = 1'b0;
            end
            cycle();
        end
        check("pause_hit", hit, 1);
        run(6);
        enable = 1'b1;
        run(12);

        sensor_bus = 16'h1111;
        run(30);
        clear_req  = 1'b1;
        clear_mask = 4'b1010;
        run(8);
        clear_req  = 1'b0;
        run(4);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < N; k++)
                    rnd_bus[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                sensor_bus = rnd_bus;
            end
            enable = $urandom_range(0, 9) != 0;
            if (clear_req && m_ack == 1) clear_req = 1'b0;
            else if (!clear_req && $urandom_range(0, 11) == 0) begin
                clear_req  = 1'b1;
                clear_mask = 4'($urandom);
            end
            if (i == 700 || i == 1400) async_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
